// File: rtl/nec_ir_transmitter_if.sv
// Key/command handshake and LED drive between the command source and the NEC IR transmitter.
// The transmitter takes the slave side; the command source (or a bench) takes the master side.
interface nec_ir_transmitter_if;
  logic [7:0] key_in;
  logic       start;
  logic       busy;
  logic       done;
  logic       unknown_key;
  logic       ir_out;

  modport master (
    output key_in,
    output start,
    input  busy,
    input  done,
    input  unknown_key,
    input  ir_out
  );

  modport slave (
    input  key_in,
    input  start,
    output busy,
    output done,
    output unknown_key,
    output ir_out
  );
endinterface

// File: rtl/nec_ir_transmitter.sv
// NEC IR transmitter: maps an 8-bit key to its 32-bit frame code and sends it MSB first
// with pulse-distance timing, gating a square-wave carrier onto the LED during marks.
module nec_ir_transmitter #(
  parameter int UNIT_CYCLES  = 28125,
  parameter int CARRIER_HALF = 658
) (
  input  logic                  clk,
  input  logic                  reset,
  nec_ir_transmitter_if.slave   tx
);

  localparam int CYC_W = $clog2(UNIT_CYCLES);
  localparam int CAR_W = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(UNIT_CYCLES - 1);
  localparam logic [CAR_W-1:0] CAR_LAST = CAR_W'(CARRIER_HALF - 1);

  typedef enum logic [2:0] {
    IDLE,
    LEADER_MARK,
    LEADER_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK
  } state_t;

  state_t           state_q;
  logic [31:0]      shift_q;
  logic [CYC_W-1:0] cyc_q;
  logic [4:0]       unit_q;
  logic [4:0]       bit_q;
  logic [CAR_W-1:0] car_q;
  logic             busy_q;
  logic             done_q;
  logic             unknown_q;
  logic             ir_q;

  logic             key_valid_d;
  logic [31:0]      key_code_d;
  logic [4:0]       dur_d;
  logic             in_mark_d;
  logic             unit_end_d;

  // Inverse of the receiver's decode table.
  always_comb begin
    key_valid_d = 1'b0;
    key_code_d  = 32'h0000_0000;
    case (tx.key_in)
      8'h09: begin
        key_valid_d = 1'b1;
        key_code_d  = 32'hB857_E02F;
      end
      default: ;
    endcase
  end

  always_comb begin
    dur_d = 5'd1;
    case (state_q)
      LEADER_MARK:  dur_d = 5'd16;
      LEADER_SPACE: dur_d = 5'd8;
      BIT_SPACE:    dur_d = shift_q[31] ? 5'd3 : 5'd1;
      default:      dur_d = 5'd1;
    endcase
  end

  assign in_mark_d  = (state_q == LEADER_MARK) || (state_q == BIT_MARK) ||
                      (state_q == STOP_MARK);
  assign unit_end_d = (cyc_q == CYC_LAST) && (unit_q == dur_d - 5'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      shift_q   <= 32'h0000_0000;
      cyc_q     <= '0;
      unit_q    <= 5'd0;
      bit_q     <= 5'd0;
      car_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      unknown_q <= 1'b0;
      ir_q      <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      unknown_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tx.start) begin
            if (key_valid_d) begin
              shift_q <= key_code_d;
              state_q <= LEADER_MARK;
              busy_q  <= 1'b1;
              cyc_q   <= '0;
              unit_q  <= 5'd0;
              bit_q   <= 5'd0;
              car_q   <= '0;
              ir_q    <= 1'b1;
            end else begin
              unknown_q <= 1'b1;
            end
          end
        end
        default: begin
          if (cyc_q == CYC_LAST) begin
            cyc_q  <= '0;
            unit_q <= unit_q + 5'd1;
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
          if (in_mark_d) begin
            if (car_q == CAR_LAST) begin
              car_q <= '0;
              ir_q  <= ~ir_q;
            end else begin
              car_q <= car_q + 1'b1;
            end
          end
          // Last cycle of the state: later assignments here override the counters above.
          if (unit_end_d) begin
            unit_q <= 5'd0;
            car_q  <= '0;
            case (state_q)
              LEADER_MARK: begin
                state_q <= LEADER_SPACE;
                ir_q    <= 1'b0;
              end
              LEADER_SPACE: begin
                state_q <= BIT_MARK;
                ir_q    <= 1'b1;
              end
              BIT_MARK: begin
                state_q <= BIT_SPACE;
                ir_q    <= 1'b0;
              end
              BIT_SPACE: begin
                shift_q <= {shift_q[30:0], 1'b0};
                bit_q   <= bit_q + 5'd1;
                state_q <= (bit_q == 5'd31) ? STOP_MARK : BIT_MARK;
                ir_q    <= 1'b1;
              end
              STOP_MARK: begin
                state_q <= IDLE;
                ir_q    <= 1'b0;
                busy_q  <= 1'b0;
                done_q  <= 1'b1;
              end
              default: begin
                state_q <= IDLE;
                ir_q    <= 1'b0;
                busy_q  <= 1'b0;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign tx.busy        = busy_q;
  assign tx.done        = done_q;
  assign tx.unknown_key = unknown_q;
  assign tx.ir_out      = ir_q;

endmodule
